sine_dds_reader: RTL

//  Read-side initiator for the sine lookup ROM: a DDS phase accumulator that issues

---
 rtl/sine_dds_reader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sine_dds_reader.sv
// ============================================================================
//  Module   : sine_dds_reader
//  Brief    : DDS phase accumulator reading a registered sine ROM and streaming
//             the returned samples on a valid/ready interface in bursts.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sine_dds_reader #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 24,
    parameter int LEN_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [PHASE_W-1:0] fcw_i,
    input  logic [PHASE_W-1:0] phase_i,
    input  logic [LEN_W-1:0]   len_i,
    output logic               rom_cen_o,
    output logic [ADDR_W-1:0]  rom_addr_o,
    input  logic [DATA_W-1:0]  rom_data_i,
    output logic [DATA_W-1:0]  sample_o,
    output logic               sample_valid_o,
    input  logic               sample_ready_i,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_fcw;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_count;
    logic               r_valid;
    logic               r_done;

    logic               w_adv;
    logic               w_issue;
    logic               w_take;

    // A read may only be issued when the output slot is free or emptying this
    // cycle, so the ROM register never changes under a stalled sample.
    assign w_adv   = ~r_valid | sample_ready_i;
    assign w_issue = (r_state == S_RUN) & w_adv & ~abort_i;
    assign w_take  = r_valid & sample_ready_i;

    assign rom_cen_o      = w_issue;
    assign rom_addr_o     = r_phase[PHASE_W-1 -: ADDR_W];
    assign sample_o       = rom_data_i;
    assign sample_valid_o = r_valid;
    assign busy_o         = (r_state != S_IDLE);
    assign done_o         = r_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_fcw   <= '0;
            r_len   <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort_i) begin
                // Any in-flight or held sample is discarded.
                r_state <= S_IDLE;
                r_valid <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_valid <= 1'b1;
                end else if (w_take) begin
                    r_valid <= 1'b0;
                end

                case (r_state)
                    S_IDLE: begin
                        if (start_i) begin
                            r_fcw   <= fcw_i;
                            r_phase <= phase_i;
                            r_len   <= len_i;
                            r_count <= '0;
                            if (len_i == '0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (w_issue) begin
                            r_phase <= r_phase + r_fcw;
                            r_count <= r_count + LEN_W'(1);
                            if (r_count == r_len - LEN_W'(1)) begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (w_take) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
